// File: rtl/imem_fetch.sv
// Instruction fetch unit: reads a 1-cycle-latency on-chip instruction memory into a 2-entry FIFO.
// Optional performance counters are built only when IMEM_FETCH_PERF_EN is defined.
module imem_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [9:0]  imem_address,
    output logic        imem_chipselect,
    output logic        imem_clken,
    output logic        imem_write,
    output logic [31:0] imem_writedata,
    output logic [3:0]  imem_byteenable,
    output logic        imem_debugaccess,
    input  logic [31:0] imem_readdata,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] data0_q, data0_d, data1_q, data1_d;

    logic        head_valid;
    logic [31:0] head_pc;
    logic [31:0] head_data;
    logic        pop;
    logic        issue;
    logic        fifo_push;

    assign imem_write       = 1'b0;
    assign imem_writedata   = 32'h0000_0000;
    assign imem_byteenable  = 4'hF;
    assign imem_debugaccess = 1'b0;
    assign imem_clken       = 1'b1;

    // An empty FIFO forwards the arriving response directly so a read shows up the cycle after
    // issue; a redirect hides whatever is buffered in the same cycle.
    always_comb begin
        head_pc   = pc0_q;
        head_data = data0_q;
        if (count_q == 2'd0) begin
            head_pc   = resp_pc_q;
            head_data = imem_readdata;
        end
        head_valid = ((count_q != 2'd0) || resp_valid_q) && !redirect_valid && !reset_reset;
    end

    assign pop = head_valid && instr_ready;

    assign issue = !reset_reset && (state_q == StRun) && !halt_req && !redirect_valid &&
                   ((count_q + {1'b0, resp_valid_q}) < 2'd2);

    assign instr_valid     = head_valid;
    assign instr_pc        = head_valid ? head_pc : 32'h0000_0000;
    assign instr_data      = head_valid ? head_data : 32'h0000_0000;
    assign imem_chipselect = issue;
    assign imem_address    = reset_reset ? 10'd0 : fetch_pc_q[11:2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:   state_d = StRun;
            StRun:    if (halt_req && !resp_valid_q) state_d = StHalted;
            StHalted: if (!halt_req) state_d = StRun;
            default:  state_d = StBoot;
        endcase
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = issue;
        resp_pc_d    = resp_pc_q;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            resp_pc_d  = fetch_pc_q;
        end
        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc & 32'hFFFF_FFFC;
            resp_valid_d = 1'b0;
        end
    end

    // A response consumed through the bypass is never written into the FIFO.
    always_comb begin
        pc0_d     = pc0_q;
        pc1_d     = pc1_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        count_d   = count_q;
        fifo_push = resp_valid_q && !((count_q == 2'd0) && pop);
        if (pop && (count_q != 2'd0)) begin
            pc0_d   = pc1_q;
            data0_d = data1_q;
            count_d = count_q - 2'd1;
        end
        if (fifo_push) begin
            if (count_d == 2'd0) begin
                pc0_d   = resp_pc_q;
                data0_d = imem_readdata;
            end else begin
                pc1_d   = resp_pc_q;
                data1_d = imem_readdata;
            end
            count_d = count_d + 2'd1;
        end
        if (redirect_valid) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= StBoot;
            fetch_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0000_0000;
            count_q      <= 2'd0;
            pc0_q        <= 32'h0000_0000;
            pc1_q        <= 32'h0000_0000;
            data0_q      <= 32'h0000_0000;
            data1_q      <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            count_q      <= count_d;
            pc0_q        <= pc0_d;
            pc1_q        <= pc1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (head_valid && !instr_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_count = fetch_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`else
    assign perf_fetch_count = 32'h0000_0000;
    assign perf_stall_count = 32'h0000_0000;
`endif

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port redirect_valid, input, 1, pulse requesting a fetch restart at redirect_pc.
REQ-005 SHALL have port redirect_pc, input, 32, new fetch byte address.
REQ-006 SHALL have port halt_req, input, 1, level; stops issue of new reads while high.
REQ-007 SHALL have port instr_valid, output, 1, instr_data/instr_pc hold a valid instruction.
REQ-008 SHALL have port instr_ready, input, 1, consumer accepts the instruction when high with instr_valid.
REQ-009 SHALL have port instr_data, output, 32, fetched instruction word.
REQ-010 SHALL have port instr_pc, output, 32, byte address of instr_data.
REQ-011 SHALL have ports imem_address (output, 10), imem_chipselect (output, 1), imem_clken (output, 1), imem_write (output, 1), imem_writedata (output, 32), imem_byteenable (output, 4), imem_debugaccess (output, 1), imem_readdata (input, 32), forming the master side of the on-chip instruction memory slave port.
REQ-012 SHALL have ports perf_fetch_count (output, 32) and perf_stall_count (output, 32).

Function
REQ-013 SHALL drive imem_write=0, imem_writedata=0, imem_byteenable=4'hF, imem_debugaccess=0, imem_clken=1 constantly.
REQ-014 SHALL issue a read by asserting imem_chipselect for one cycle with imem_address=fetch_pc[11:2]; readdata is valid exactly 1 cycle later (fixed latency, no waitrequest).
REQ-015 SHALL buffer responses in a 2-entry FIFO; issue only when FIFO occupancy + in-flight reads < 2, giving one instruction per cycle when instr_ready is held high.
REQ-016 SHALL advance fetch_pc by 4 on each issue, wrapping modulo 2^32; imem_address therefore wraps 1023 -> 0.
REQ-017 SHALL present the FIFO head on instr_valid/instr_data/instr_pc; an entry is popped on the cycle instr_valid && instr_ready; outputs SHALL stay stable while instr_valid && !instr_ready.
REQ-018 SHALL implement FSM states BOOT, RUN, HALTED: BOOT -> RUN after one cycle; RUN -> HALTED when halt_req=1 and no read in flight; HALTED -> RUN when halt_req=0; no issue in BOOT or HALTED.
REQ-019 SHALL, on redirect_valid, in the same cycle empty the FIFO, drop any in-flight response (no instr_valid for it), and set fetch_pc={redirect_pc[31:2],2'b00}; the first read to the new address issues on the next cycle if in RUN and halt_req=0.
REQ-020 SHALL give redirect priority over a simultaneous pop, issue, or halt_req; halt_req only blocks issue.
REQ-021 SHALL place the first redirected instruction on instr_valid 2 cycles after the redirect cycle.
REQ-022 SHALL keep buffered instructions visible in HALTED until popped or redirected.

Reset
REQ-023 SHALL, while reset_reset=1, set state=BOOT, fetch_pc=RESET_PC with bits [1:0] forced to 0, FIFO empty, in-flight cleared, instr_valid=0, instr_data=0, instr_pc=0, imem_chipselect=0, imem_address=0, perf counters=0.
REQ-024 SHALL discard any response returning in the cycle after reset deasserts if its read was issued before reset.

Configuration
REQ-025 SHALL, with macro IMEM_FETCH_PERF_EN defined, increment perf_fetch_count on each pop and perf_stall_count on each cycle with instr_valid=1 and instr_ready=0, both wrapping at 2^32.
REQ-026 SHALL, without IMEM_FETCH_PERF_EN, tie perf_fetch_count and perf_stall_count to 0 and omit counter logic.

Verification
REQ-027 Reset release, RESET_PC=0, memory word i=i+0x100, instr_ready=1 -> first instr_valid at cycle 2 after release, pc 0x0,0x4,0x8 with data 0x100,0x101,0x102 on consecutive cycles.
REQ-028 instr_ready low for 5 cycles mid-stream -> instr_pc/instr_data held stable, no word skipped or duplicated, perf_stall_count=5 (macro on).
REQ-029 redirect_valid with redirect_pc=0x0000_0043 while FIFO full -> no stale instruction delivered, next instr_pc=0x40 two cycles later.
REQ-030 fetch_pc=0xFFC -> imem_address 0x3FF then 0x000, instr_pc 0xFFC then 0x1000.
REQ-031 halt_req high for 10 cycles -> chipselect low after in-flight read retires, state HALTED, buffered words still drain; release resumes at next sequential pc.
REQ-032 reset_reset asserted one cycle after an issue -> instr_valid=0 next cycle, response dropped, fetch restarts at RESET_PC.
